// File: rtl/servo_step_pwm.sv
// servo_step_pwm: accumulates signed step commands into a saturating servo position
// and drives a hobby-servo PWM signal. The pulse width changes only at frame
// boundaries, so the servo never sees a truncated or stretched pulse.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   step_i         signed two's-complement step, -64..+63
//   step_valid_i   qualifier; step_i is applied on every cycle this is high
//   servo_o        registered PWM output
//   position_o     current accumulated position
//   at_min_o       high while position is 0
//   at_max_o       high while position is 2^POS_BITS-1
//   frame_start_o  one-cycle pulse coincident with servo_o rising at frame start
module servo_step_pwm #(
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned MIN_PULSE     = 50000,
    parameter int unsigned UNIT_CYCLES   = 196,
    parameter int unsigned POS_BITS      = 8,
    parameter int unsigned POS_CENTER    = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [6:0]          step_i,
    input  logic                step_valid_i,
    output logic                servo_o,
    output logic [POS_BITS-1:0] position_o,
    output logic                at_min_o,
    output logic                at_max_o,
    output logic                frame_start_o
);

    localparam int unsigned CntW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    // Two extra bits hold both the sign and the overflow of position + step.
    localparam int unsigned SumW = POS_BITS + 2;

    localparam logic [POS_BITS-1:0] PosMax     = '1;
    localparam logic [POS_BITS-1:0] PosReset   = POS_BITS'(POS_CENTER);
    localparam logic [CntW-1:0]     CntLast    = CntW'(PERIOD_CYCLES - 1);
    localparam logic [31:0]         PulseReset = 32'(MIN_PULSE + POS_CENTER * UNIT_CYCLES);

    typedef enum logic [0:0] {
        StLow,
        StHigh
    } state_e;

    state_e              state_q, state_d;
    logic [POS_BITS-1:0] position_q, position_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [31:0]         pulse_q, pulse_d;
    logic                frame_start_q, frame_start_d;

    logic [SumW-1:0]     step_ext;
    logic [SumW-1:0]     sum;
    logic                wrap;

    always_comb begin
        step_ext = {{(SumW - 7){step_i[6]}}, step_i};
        sum      = {2'b00, position_q} + step_ext;
        wrap     = (cnt_q == CntLast);

        // Saturating accumulate: top bit set means negative, next bit means overflow.
        position_d = position_q;
        if (step_valid_i) begin
            if (sum[SumW-1]) begin
                position_d = '0;
            end else if (sum[POS_BITS]) begin
                position_d = PosMax;
            end else begin
                position_d = sum[POS_BITS-1:0];
            end
        end

        cnt_d = wrap ? '0 : cnt_q + CntW'(1);

        // Width is sampled from the position held before the wrap edge.
        pulse_d = pulse_q;
        if (wrap) begin
            pulse_d = 32'(MIN_PULSE) + 32'(position_q) * 32'(UNIT_CYCLES);
        end

        state_d       = (32'(cnt_q) < pulse_q) ? StHigh : StLow;
        frame_start_d = (cnt_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StLow;
            position_q    <= PosReset;
            cnt_q         <= '0;
            pulse_q       <= PulseReset;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            position_q    <= position_d;
            cnt_q         <= cnt_d;
            pulse_q       <= pulse_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign servo_o       = (state_q == StHigh);
    assign position_o    = position_q;
    assign at_min_o      = (position_q == '0);
    assign at_max_o      = (position_q == PosMax);
    assign frame_start_o = frame_start_q;

endmodule
